// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch condition codes, flag bit positions and
// the EX/MEM stage FSM encoding.
package cpu_pkg;

    localparam logic [2:0] COND_NE  = 3'd0;
    localparam logic [2:0] COND_EQ  = 3'd1;
    localparam logic [2:0] COND_GT  = 3'd2;
    localparam logic [2:0] COND_LT  = 3'd3;
    localparam logic [2:0] COND_GTE = 3'd4;
    localparam logic [2:0] COND_LTE = 3'd5;
    localparam logic [2:0] COND_OVF = 3'd6;
    localparam logic [2:0] COND_UNC = 3'd7;

    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 0;

    localparam int unsigned FLAGS_W = 3;
    localparam int unsigned COND_W  = 3;
    localparam int unsigned RD_W    = 4;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_SQUASH = 2'd1,
        ST_HALT   = 2'd2
    } stageState_e;

endpackage

// File: rtl/ex_mem_flag_stage_if.sv
// EX-side inputs and MEM-side outputs of the EX/MEM flag stage.
interface ex_mem_flag_stage_if #(
    parameter int unsigned DW = 16
);
    import cpu_pkg::*;

    logic               ex_valid_i;
    logic [DW-1:0]      ex_dst_i;
    logic               ex_n_i;
    logic               ex_z_i;
    logic               ex_v_i;
    logic               ex_flag_we_i;
    logic               ex_is_branch_i;
    logic [COND_W-1:0]  ex_cond_i;
    logic [DW-1:0]      ex_target_i;
    logic [RD_W-1:0]    ex_rd_i;
    logic               ex_reg_we_i;
    logic               ex_mem_re_i;
    logic               ex_mem_we_i;
    logic [DW-1:0]      ex_store_data_i;
    logic               ex_hlt_i;
    logic               stall_i;

    logic               mem_valid_o;
    logic [DW-1:0]      mem_alu_o;
    logic [RD_W-1:0]    mem_rd_o;
    logic               mem_reg_we_o;
    logic               mem_mem_re_o;
    logic               mem_mem_we_o;
    logic [DW-1:0]      mem_store_data_o;
    logic [FLAGS_W-1:0] flags_o;
    logic               redirect_o;
    logic [DW-1:0]      redirect_pc_o;
    logic               halted_o;

    modport master (
        output ex_valid_i, ex_dst_i, ex_n_i, ex_z_i, ex_v_i, ex_flag_we_i,
               ex_is_branch_i, ex_cond_i, ex_target_i, ex_rd_i, ex_reg_we_i,
               ex_mem_re_i, ex_mem_we_i, ex_store_data_i, ex_hlt_i, stall_i,
        input  mem_valid_o, mem_alu_o, mem_rd_o, mem_reg_we_o, mem_mem_re_o,
               mem_mem_we_o, mem_store_data_o, flags_o, redirect_o,
               redirect_pc_o, halted_o
    );

    modport slave (
        input  ex_valid_i, ex_dst_i, ex_n_i, ex_z_i, ex_v_i, ex_flag_we_i,
               ex_is_branch_i, ex_cond_i, ex_target_i, ex_rd_i, ex_reg_we_i,
               ex_mem_re_i, ex_mem_we_i, ex_store_data_i, ex_hlt_i, stall_i,
        output mem_valid_o, mem_alu_o, mem_rd_o, mem_reg_we_o, mem_mem_re_o,
               mem_mem_we_o, mem_store_data_o, flags_o, redirect_o,
               redirect_pc_o, halted_o
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational evaluation of a branch condition code against the N/Z/V flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [FLAGS_W-1:0] flags,
    input  logic [COND_W-1:0]  cond,
    output logic               taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NE:  taken = !flags[FLAG_Z];
            COND_EQ:  taken = flags[FLAG_Z];
            COND_GT:  taken = !flags[FLAG_Z] && !flags[FLAG_N];
            COND_LT:  taken = flags[FLAG_N];
            COND_GTE: taken = flags[FLAG_Z] || !flags[FLAG_N];
            COND_LTE: taken = flags[FLAG_N] || flags[FLAG_Z];
            COND_OVF: taken = flags[FLAG_V];
            COND_UNC: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with architectural N/Z/V flags, branch resolution,
// one-shot fetch redirect, wrong-path squash and sticky halt.
module ex_mem_flag_stage
    import cpu_pkg::*;
#(
    parameter int unsigned SQUASH_CYC = 2,
    parameter int unsigned DW         = 16
) (
    input logic               clk,
    input logic               rst_n,
    ex_mem_flag_stage_if.slave bus
);

    stageState_e        stateQ, stateD;
    logic [CNT_W-1:0]   cntQ, cntD;
    logic               validQ, validD;
    logic [DW-1:0]      aluQ, aluD;
    logic [RD_W-1:0]    rdQ, rdD;
    logic               regWeQ, regWeD;
    logic               memReQ, memReD;
    logic               memWeQ, memWeD;
    logic [DW-1:0]      storeQ, storeD;
    logic [FLAGS_W-1:0] flagsQ, flagsD;
    logic               redirectQ, redirectD;
    logic [DW-1:0]      redirectPcQ, redirectPcD;
    logic               haltedQ, haltedD;

    logic               accept;
    logic               condTrue;
    logic               taken;

    branch_cond uCond (
        .flags (flagsQ),
        .cond  (bus.ex_cond_i),
        .taken (condTrue)
    );

    assign accept = bus.ex_valid_i && !bus.stall_i && (stateQ == ST_RUN);
    assign taken  = accept && bus.ex_is_branch_i && condTrue;

    // Next-state and next-output logic; a stall leaves every register as is.
    always_comb begin
        stateD      = stateQ;
        cntD        = cntQ;
        validD      = validQ;
        aluD        = aluQ;
        rdD         = rdQ;
        regWeD      = regWeQ;
        memReD      = memReQ;
        memWeD      = memWeQ;
        storeD      = storeQ;
        flagsD      = flagsQ;
        redirectD   = redirectQ;
        redirectPcD = redirectPcQ;
        haltedD     = haltedQ;

        if (!bus.stall_i) begin
            validD    = accept;
            aluD      = bus.ex_dst_i;
            rdD       = bus.ex_rd_i;
            regWeD    = accept && bus.ex_reg_we_i;
            memReD    = accept && bus.ex_mem_re_i;
            memWeD    = accept && bus.ex_mem_we_i;
            storeD    = bus.ex_store_data_i;
            redirectD = 1'b0;

            case (stateQ)
                ST_RUN: begin
                    if (accept && bus.ex_flag_we_i) begin
                        flagsD = {bus.ex_n_i, bus.ex_z_i, bus.ex_v_i};
                    end
                    // Halt outranks a simultaneously taken branch.
                    if (accept && bus.ex_hlt_i) begin
                        stateD  = ST_HALT;
                        haltedD = 1'b1;
                    end else if (taken) begin
                        stateD      = ST_SQUASH;
                        cntD        = CNT_W'(SQUASH_CYC);
                        redirectD   = 1'b1;
                        redirectPcD = bus.ex_target_i;
                    end
                end
                ST_SQUASH: begin
                    cntD = cntQ - CNT_W'(1);
                    if (cntQ == CNT_W'(1)) begin
                        stateD = ST_RUN;
                    end
                end
                ST_HALT: begin
                    stateD = ST_HALT;
                end
                default: begin
                    stateD = ST_RUN;
                    cntD   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ      <= ST_RUN;
            cntQ        <= '0;
            validQ      <= 1'b0;
            aluQ        <= '0;
            rdQ         <= '0;
            regWeQ      <= 1'b0;
            memReQ      <= 1'b0;
            memWeQ      <= 1'b0;
            storeQ      <= '0;
            flagsQ      <= '0;
            redirectQ   <= 1'b0;
            redirectPcQ <= '0;
            haltedQ     <= 1'b0;
        end else begin
            stateQ      <= stateD;
            cntQ        <= cntD;
            validQ      <= validD;
            aluQ        <= aluD;
            rdQ         <= rdD;
            regWeQ      <= regWeD;
            memReQ      <= memReD;
            memWeQ      <= memWeD;
            storeQ      <= storeD;
            flagsQ      <= flagsD;
            redirectQ   <= redirectD;
            redirectPcQ <= redirectPcD;
            haltedQ     <= haltedD;
        end
    end

    assign bus.mem_valid_o      = validQ;
    assign bus.mem_alu_o        = aluQ;
    assign bus.mem_rd_o         = rdQ;
    assign bus.mem_reg_we_o     = regWeQ;
    assign bus.mem_mem_re_o     = memReQ;
    assign bus.mem_mem_we_o     = memWeQ;
    assign bus.mem_store_data_o = storeQ;
    assign bus.flags_o          = flagsQ;
    assign bus.redirect_o       = redirectQ;
    assign bus.redirect_pc_o    = redirectPcQ;
    assign bus.halted_o         = haltedQ;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Bench for ex_mem_flag_stage: directed table, hand sequences for stall,
// reset-in-squash and halt, plus random traffic against a reference model.
module tb_ex_mem_flag_stage;
    import cpu_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned SQ = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ex_mem_flag_stage_if #(.DW(DW)) bus ();

    ex_mem_flag_stage #(.SQUASH_CYC(SQ), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [15:0] dst;
        logic [2:0]  nzv;
        logic        flagWe;
        logic        isBr;
        logic [2:0]  cond;
        logic [15:0] target;
        logic [3:0]  rd;
        logic        regWe;
        logic        memRe;
        logic        memWe;
        logic [15:0] storeData;
        logic        hlt;
        logic        stall;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] alu;
        logic [3:0]  rd;
        logic        regWe;
        logic        memRe;
        logic        memWe;
        logic [15:0] store;
        logic [2:0]  flags;
        logic        redirect;
        logic [15:0] pc;
        logic        halted;
    } out_t;

    typedef struct packed {
        stim_t       s;
        logic        expValid;
        logic [15:0] expAlu;
        logic [2:0]  expFlags;
        logic        expRedir;
        logic [15:0] expPc;
        logic        expRegWe;
    } vec_t;

    // Reference model: flags, remaining squash slots, halt, expected outputs.
    out_t exp;
    int   squashLeft;
    bit   mHalted;

    function automatic bit condHolds(input logic [2:0] f, input logic [2:0] c);
        bit n, z, v;
        n = f[2]; z = f[1]; v = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic stim_t mk(input logic valid, input logic [15:0] dst,
                                 input logic [2:0] nzv, input logic flagWe,
                                 input logic isBr, input logic [2:0] cond,
                                 input logic [15:0] target, input logic [3:0] rd,
                                 input logic regWe);
        stim_t s;
        s = '0;
        s.valid = valid; s.dst = dst; s.nzv = nzv; s.flagWe = flagWe;
        s.isBr = isBr; s.cond = cond; s.target = target; s.rd = rd;
        s.regWe = regWe;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic modelReset();
        exp = '0;
        squashLeft = 0;
        mHalted = 1'b0;
    endtask

    task automatic modelEdge(input stim_t s);
        bit accept, tk;
        if (!s.stall) begin
            accept = s.valid && (squashLeft == 0) && !mHalted;
            exp.redirect = 1'b0;
            exp.valid = accept;
            exp.alu   = s.dst;
            exp.rd    = s.rd;
            exp.regWe = accept && s.regWe;
            exp.memRe = accept && s.memRe;
            exp.memWe = accept && s.memWe;
            exp.store = s.storeData;
            if (squashLeft > 0) begin
                squashLeft--;
            end else if (accept) begin
                tk = s.isBr && condHolds(exp.flags, s.cond);
                if (s.hlt) begin
                    mHalted = 1'b1;
                end else if (tk) begin
                    squashLeft   = SQ;
                    exp.redirect = 1'b1;
                    exp.pc       = s.target;
                end
                if (s.flagWe) exp.flags = s.nzv;
            end
            exp.halted = mHalted;
        end
    endtask

    task automatic compareModel(input string tag);
        chk({tag, ".valid"},    32'(bus.mem_valid_o),      32'(exp.valid));
        chk({tag, ".alu"},      32'(bus.mem_alu_o),        32'(exp.alu));
        chk({tag, ".rd"},       32'(bus.mem_rd_o),         32'(exp.rd));
        chk({tag, ".regWe"},    32'(bus.mem_reg_we_o),     32'(exp.regWe));
        chk({tag, ".memRe"},    32'(bus.mem_mem_re_o),     32'(exp.memRe));
        chk({tag, ".memWe"},    32'(bus.mem_mem_we_o),     32'(exp.memWe));
        chk({tag, ".store"},    32'(bus.mem_store_data_o), 32'(exp.store));
        chk({tag, ".flags"},    32'(bus.flags_o),          32'(exp.flags));
        chk({tag, ".redirect"}, 32'(bus.redirect_o),       32'(exp.redirect));
        chk({tag, ".pc"},       32'(bus.redirect_pc_o),    32'(exp.pc));
        chk({tag, ".halted"},   32'(bus.halted_o),         32'(exp.halted));
    endtask

    task automatic drive(input stim_t s);
        bus.ex_valid_i      = s.valid;
        bus.ex_dst_i        = s.dst;
        bus.ex_n_i          = s.nzv[2];
        bus.ex_z_i          = s.nzv[1];
        bus.ex_v_i          = s.nzv[0];
        bus.ex_flag_we_i    = s.flagWe;
        bus.ex_is_branch_i  = s.isBr;
        bus.ex_cond_i       = s.cond;
        bus.ex_target_i     = s.target;
        bus.ex_rd_i         = s.rd;
        bus.ex_reg_we_i     = s.regWe;
        bus.ex_mem_re_i     = s.memRe;
        bus.ex_mem_we_i     = s.memWe;
        bus.ex_store_data_i = s.storeData;
        bus.ex_hlt_i        = s.hlt;
        bus.stall_i         = s.stall;
    endtask

    // Apply one input vector across a rising edge and check against the model.
    task automatic step(input stim_t s, input string tag);
        drive(s);
        modelEdge(s);
        @(posedge clk);
        #1;
        compareModel(tag);
    endtask

    vec_t  tbl [12];
    stim_t idle;
    stim_t s;

    initial begin
        idle = '0;
        drive(idle);
        modelReset();

        // Reset state
        #3;
        compareModel("reset");
        @(negedge clk);
        rst_n = 1'b1;

        //          valid dst      nzv    fwe br cond target   rd regWe  | val alu      flags  red pc       rwe
        tbl[0]  = '{mk(1, 16'h0005, 3'b000, 1, 0, 3'd0, 16'h0000, 3, 1), 1, 16'h0005, 3'b000, 0, 16'h0000, 1};
        tbl[1]  = '{mk(1, 16'h0000, 3'b010, 1, 0, 3'd0, 16'h0000, 4, 1), 1, 16'h0000, 3'b010, 0, 16'h0000, 1};
        tbl[2]  = '{mk(1, 16'h0000, 3'b000, 0, 1, 3'd1, 16'h0040, 0, 0), 1, 16'h0000, 3'b010, 1, 16'h0040, 0};
        tbl[3]  = '{mk(1, 16'h0007, 3'b000, 1, 0, 3'd0, 16'h0000, 5, 1), 0, 16'h0007, 3'b010, 0, 16'h0040, 0};
        tbl[4]  = '{mk(1, 16'h0008, 3'b000, 1, 0, 3'd0, 16'h0000, 5, 1), 0, 16'h0008, 3'b010, 0, 16'h0040, 0};
        tbl[5]  = '{mk(1, 16'h0009, 3'b010, 1, 0, 3'd0, 16'h0000, 5, 1), 1, 16'h0009, 3'b010, 0, 16'h0040, 1};
        tbl[6]  = '{mk(1, 16'h0000, 3'b000, 0, 1, 3'd0, 16'h0080, 0, 0), 1, 16'h0000, 3'b010, 0, 16'h0040, 0};
        tbl[7]  = '{mk(0, 16'h0011, 3'b000, 1, 0, 3'd0, 16'h0000, 6, 1), 0, 16'h0011, 3'b010, 0, 16'h0040, 0};
        tbl[8]  = '{mk(1, 16'h0000, 3'b000, 0, 1, 3'd5, 16'h0100, 0, 0), 1, 16'h0000, 3'b010, 1, 16'h0100, 0};
        tbl[9]  = '{mk(0, 16'h0000, 3'b000, 0, 0, 3'd0, 16'h0000, 0, 0), 0, 16'h0000, 3'b010, 0, 16'h0100, 0};
        tbl[10] = '{mk(0, 16'h0000, 3'b000, 0, 0, 3'd0, 16'h0000, 0, 0), 0, 16'h0000, 3'b010, 0, 16'h0100, 0};
        tbl[11] = '{mk(1, 16'h1234, 3'b000, 1, 0, 3'd0, 16'h0000, 5, 1), 1, 16'h1234, 3'b000, 0, 16'h0100, 1};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].s, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.valid", i), 32'(bus.mem_valid_o),   32'(tbl[i].expValid));
            chk($sformatf("tbl%0d.alu", i),   32'(bus.mem_alu_o),     32'(tbl[i].expAlu));
            chk($sformatf("tbl%0d.flags", i), 32'(bus.flags_o),       32'(tbl[i].expFlags));
            chk($sformatf("tbl%0d.redir", i), 32'(bus.redirect_o),    32'(tbl[i].expRedir));
            chk($sformatf("tbl%0d.pc", i),    32'(bus.redirect_pc_o), 32'(tbl[i].expPc));
            chk($sformatf("tbl%0d.regWe", i), 32'(bus.mem_reg_we_o),  32'(tbl[i].expRegWe));
        end

        // Taken branch followed by a 3-cycle stall holding the redirect
        step(mk(1, 16'h0000, 3'b000, 0, 1, COND_UNC, 16'hBEEF, 0, 0), "stBr");
        chk("stBr.redir", 32'(bus.redirect_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            s = mk(1, 16'(16'h0A00 + i), 3'b111, 1, 1, COND_UNC, 16'h1111, 7, 1);
            s.stall = 1'b1;
            step(s, "stHold");
            chk("stHold.redir", 32'(bus.redirect_o),    32'd1);
            chk("stHold.pc",    32'(bus.redirect_pc_o), 32'hBEEF);
            chk("stHold.valid", 32'(bus.mem_valid_o),   32'd1);
        end
        step(mk(1, 16'h0021, 3'b100, 1, 0, 3'd0, 16'h0000, 1, 1), "stSq1");
        chk("stSq1.redir", 32'(bus.redirect_o),  32'd0);
        chk("stSq1.valid", 32'(bus.mem_valid_o), 32'd0);
        step(mk(1, 16'h0022, 3'b100, 1, 0, 3'd0, 16'h0000, 1, 1), "stSq2");
        chk("stSq2.valid", 32'(bus.mem_valid_o), 32'd0);
        step(mk(1, 16'h0023, 3'b100, 1, 0, 3'd0, 16'h0000, 1, 1), "stPass");
        chk("stPass.valid", 32'(bus.mem_valid_o), 32'd1);
        chk("stPass.flags", 32'(bus.flags_o),     32'b100);

        // Asynchronous reset between edges while one squash slot remains
        step(mk(1, 16'h0000, 3'b000, 0, 1, COND_UNC, 16'h0200, 0, 0), "rsBr");
        step(idle, "rsSq");
        rst_n = 1'b0;
        #1;
        modelReset();
        compareModel("rsMid");
        chk("rsMid.redir", 32'(bus.redirect_o), 32'd0);
        #1;
        rst_n = 1'b1;
        step(mk(1, 16'h1234, 3'b000, 1, 0, 3'd0, 16'h0000, 2, 1), "rsAdd");
        chk("rsAdd.valid", 32'(bus.mem_valid_o), 32'd1);
        chk("rsAdd.alu",   32'(bus.mem_alu_o),   32'h1234);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            s = '0;
            s.valid     = ($urandom_range(0, 9) < 8);
            s.dst       = 16'($urandom);
            s.nzv       = 3'($urandom);
            s.flagWe    = 1'($urandom);
            s.isBr      = ($urandom_range(0, 3) == 0);
            s.cond      = 3'($urandom);
            s.target    = 16'($urandom);
            s.rd        = 4'($urandom);
            s.regWe     = 1'($urandom);
            s.memRe     = 1'($urandom);
            s.memWe     = 1'($urandom);
            s.storeData = 16'($urandom);
            s.stall     = ($urandom_range(0, 4) == 0);
            step(s, "rnd");
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                #1;
                modelReset();
                compareModel("rndRst");
                #1;
                rst_n = 1'b1;
            end
        end

        // Halt together with a taken branch, then everything is dropped
        for (int i = 0; i < 3; i++) step(idle, "hPre");
        s = mk(1, 16'h00FF, 3'b101, 1, 1, COND_UNC, 16'h0055, 9, 1);
        s.hlt = 1'b1;
        step(s, "hlt");
        chk("hlt.valid",  32'(bus.mem_valid_o), 32'd1);
        chk("hlt.halted", 32'(bus.halted_o),    32'd1);
        chk("hlt.redir",  32'(bus.redirect_o),  32'd0);
        chk("hlt.flags",  32'(bus.flags_o),     32'b101);
        for (int i = 0; i < 5; i++) begin
            step(mk(1, 16'h0300, 3'b010, 1, 1, COND_UNC, 16'h0066, 3, 1), "hDrop");
            chk("hDrop.valid", 32'(bus.mem_valid_o), 32'd0);
            chk("hDrop.flags", 32'(bus.flags_o),     32'b101);
            chk("hDrop.redir", 32'(bus.redirect_o),  32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_flag_stage.md
Name: ex_mem_flag_stage

Overview:
- Sits directly downstream of the 16-bit saturating ALU.
- Registers the ALU result and control into the EX/MEM pipeline register.
- Holds the architectural N/Z/V flag register that is fed back to the ALU's flag input.
- Resolves conditional branches against those flags, issues a one-shot fetch redirect, and squashes wrong-path instructions behind a taken branch. Also latches halt.

Parameters:
- SQUASH_CYC, 2, number of accepted-slot cycles dropped after a taken branch (range 1-7).
- DW, 16, datapath width.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  an instruction is present in EX.
- ex_dst_i  in  DW  ALU result.
- ex_n_i, ex_z_i, ex_v_i  in  1 each  flags from the ALU.
- ex_flag_we_i  in  1  instruction updates the flags.
- ex_is_branch_i  in  1  conditional or unconditional branch.
- ex_cond_i  in  3  branch condition code.
- ex_target_i  in  DW  branch target PC.
- ex_rd_i  in  4  destination register.
- ex_reg_we_i, ex_mem_re_i, ex_mem_we_i  in  1 each  writeback, load and store controls.
- ex_store_data_i  in  DW  store data.
- ex_hlt_i  in  1  halt instruction.
- stall_i  in  1  downstream stall; freezes the whole block.
- mem_valid_o  out  1  EX/MEM slot is valid.
- mem_alu_o  out  DW  registered result.
- mem_rd_o  out  4  registered destination register.
- mem_reg_we_o, mem_mem_re_o, mem_mem_we_o  out  1 each  registered controls, already gated by valid.
- mem_store_data_o  out  DW  registered store data.
- flags_o  out  3  {N,Z,V}: bit2=N, bit1=Z, bit0=V.
- redirect_o  out  1  fetch redirect pulse.
- redirect_pc_o  out  DW  redirect target.
- halted_o  out  1  sticky halt.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All outputs are 0, flags_o=3'b000.
  - FSM enters RUN; the squash counter is 0.
- Stall:
  - stall_i=1 holds every register: pipeline register, flags, FSM, counter, redirect_o.
  - Nothing is accepted or dropped while stalled.
- Acceptance: accept = ex_valid_i & !stall_i & (state==RUN).
- EX/MEM pipeline register:
  - Latency is 1 cycle.
  - On a non-stalled edge, payload <= inputs and mem_valid_o <= accept.
  - mem_reg_we_o, mem_mem_re_o and mem_mem_we_o are forced to 0 when the slot is not accepted.
- Flag register:
  - On accept & ex_flag_we_i: flags <= {ex_n_i, ex_z_i, ex_v_i}.
  - In all other cases the flags hold.
  - A branch in EX evaluates against the current flags_o value, which reflects the immediately older instruction. No forwarding is needed.
- Condition codes:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: N | Z
  - 110 OVF: V
  - 111 UNCOND: 1
- Branch handling:
  - taken = accept & ex_is_branch_i & cond_true.
  - A branch occupies the slot with mem_valid_o=1 and does not write the register file unless ex_reg_we_i is set.
- FSM states: RUN, SQUASH, HALT.
  - RUN, on taken: go to SQUASH; cnt <= SQUASH_CYC; redirect_o <= 1; redirect_pc_o <= ex_target_i.
  - RUN, on accept & ex_hlt_i: go to HALT; halted_o <= 1. The HLT itself passes with mem_valid_o=1. If a halt and a taken branch arrive together, the halt wins.
  - SQUASH, each non-stalled cycle: the input is dropped (mem_valid_o <= 0, no flag update, no branch or halt evaluation) and cnt decrements. When cnt reaches 1 and the edge occurs, go to RUN.
  - HALT: all inputs are dropped and mem_valid_o <= 0. Only reset leaves HALT.
- redirect_o:
  - High for exactly one non-stalled cycle. It is cleared on the first non-stalled edge after being set.
  - If stalled, it stays high until that edge.
  - redirect_pc_o holds its last value.
- A taken branch cannot occur in SQUASH because all input there is dropped.
- Reset asserted mid-SQUASH aborts the squash; no redirect survives reset.

Decomposition:
- Shared package cpu_pkg holds:
  - condition-code constants (COND_NE..COND_UNC);
  - flag bit indices (FLAG_N=2, FLAG_Z=1, FLAG_V=0);
  - FSM state encoding (ST_RUN, ST_SQUASH, ST_HALT).
- One combinational sub-module, branch_cond: inputs flags[2:0] and cond[2:0], output taken.
- Everything else (pipeline register, flag register, FSM, counter) lives in ex_mem_flag_stage.

Test Plan:
- ADD, dst 0x0005, NZV=000, flag_we=1, rd=3, reg_we=1 -> next cycle mem_valid_o=1, mem_alu_o=0x0005, mem_rd_o=3, mem_reg_we_o=1, flags_o=000.
- SUB with Z=1, flag_we, then branch EQ with target 0x0040 -> next cycle redirect_o=1 and redirect_pc_o=0x0040 for one cycle. The next two valid inputs (ADD with Z=0, flag_we) give mem_valid_o=0 and flags stay 010. The third input passes.
- flags=010, branch NE target 0x0080 -> no redirect; mem_valid_o=1 with all controls 0; FSM stays in RUN.
- Taken branch, then stall_i=1 for 3 cycles -> redirect_o stays 1 and all outputs hold. On unstall, redirect_o drops after one edge, then 2 squashed slots follow.
- HLT accepted -> mem_valid_o=1 for the HLT, halted_o=1 next cycle; 5 further valid inputs give mem_valid_o=0 and flags unchanged.
- rst_n pulsed low between edges during SQUASH (cnt=1) -> all outputs 0 immediately. After release, the next valid ADD 0x1234 passes (mem_alu_o=0x1234).
